// File: rtl/ex_md_pkg.sv
// ex_md_pkg
// Shared definitions for the EX-stage multiply/divide unit.
// MD_OP_* : 3-bit M-extension operation encodings driven by ID/EX.
// md_state_t : sequencing states of the iterative unit.
package ex_md_pkg;

  localparam logic [2:0] MD_OP_MUL    = 3'd0;
  localparam logic [2:0] MD_OP_MULH   = 3'd1;
  localparam logic [2:0] MD_OP_MULHSU = 3'd2;
  localparam logic [2:0] MD_OP_MULHU  = 3'd3;
  localparam logic [2:0] MD_OP_DIV    = 3'd4;
  localparam logic [2:0] MD_OP_DIVU   = 3'd5;
  localparam logic [2:0] MD_OP_REM    = 3'd6;
  localparam logic [2:0] MD_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/ex_md_sign_fix.sv
// ex_md_sign_fix
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of a finished result.
// Ports:
//   val_i : W-bit input value
//   neg_i : negate when high
//   res_o : val_i or -val_i
module ex_md_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] res_o
);

  assign res_o = neg_i ? (~val_i + {{(W-1){1'b0}}, 1'b1}) : val_i;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Works on operand magnitudes (shift-add multiply, restoring divide, one
// step per cycle) and fixes the result sign when the operation finishes.
// Optional feature macro: EX_MD_EARLY_OUT_EN -- divide by zero, signed
// overflow and multiplies with a zero operand skip CALC entirely.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   ID_EX_md_valid  : request present in EX
//   ID_EX_md_op     : MD_OP_* operation code
//   EX_md_op1/op2   : forwarded rs1/rs2 values
//   ID_EX_rd        : destination register of the request
//   EX_flush        : abort anything in flight
//   EX_md_busy      : combinational stall request
//   EX_md_done      : registered one-cycle result-valid pulse
//   EX_md_result    : registered result, held until the next completion
//   EX_md_rd        : registered destination of the result
module ex_muldiv_unit
  import ex_md_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ID_EX_md_valid,
  input  logic [2:0]      ID_EX_md_op,
  input  logic [XLEN-1:0] EX_md_op1,
  input  logic [XLEN-1:0] EX_md_op2,
  input  logic [RD_W-1:0] ID_EX_rd,
  input  logic            EX_flush,
  output logic            EX_md_busy,
  output logic            EX_md_done,
  output logic [XLEN-1:0] EX_md_result,
  output logic [RD_W-1:0] EX_md_rd
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  md_state_t         stateQ, stateD;
  logic [2:0]        opQ;
  logic [RD_W-1:0]   rdQ;
  logic [2*XLEN-1:0] accQ;
  logic [XLEN-1:0]   bQ;
  logic [CW-1:0]     cntQ;
  logic              negResQ, negRemQ, divZeroQ, ovfQ;
  logic [XLEN-1:0]   dividendQ;
  logic              doneQ;
  logic [XLEN-1:0]   resultQ;
  logic [RD_W-1:0]   rdOutQ;

  logic              accept, aSigned, bSigned, negA, negB;
  logic              divZeroIn, ovfIn, earlyIn;
  logic [XLEN-1:0]   aMag, bMag;
  logic [XLEN:0]     mulSum, divShift, divDiff;
  logic [2*XLEN-1:0] mulNext, divNext, accNext, prodFixed;
  logic [XLEN-1:0]   divRaw, divFixed, calcResult, doneResult;
  logic              divNeg;
  logic [RD_W-1:0]   doneRd;

  // Forced results for the special cases; a multiply only lands here
  // through the zero-operand early exit, whose product is zero.
  function automatic logic [XLEN-1:0] specialResult(input logic [2:0] op,
                                                    input logic divZero,
                                                    input logic [XLEN-1:0] dividend);
    if (!op[2])       return '0;
    else if (divZero) return op[1] ? dividend : {XLEN{1'b1}};
    else              return op[1] ? '0 : MIN_VAL;
  endfunction

  // Request decode: which operands are signed and which special cases apply.
  // MUL is treated as unsigned since its low half is sign-independent.
  always_comb begin
    accept    = (stateQ == IDLE) & ID_EX_md_valid & ~EX_flush;
    aSigned   = (ID_EX_md_op == MD_OP_MULH) | (ID_EX_md_op == MD_OP_MULHSU) |
                (ID_EX_md_op == MD_OP_DIV)  | (ID_EX_md_op == MD_OP_REM);
    bSigned   = (ID_EX_md_op == MD_OP_MULH) | (ID_EX_md_op == MD_OP_DIV) |
                (ID_EX_md_op == MD_OP_REM);
    negA      = aSigned & EX_md_op1[XLEN-1];
    negB      = bSigned & EX_md_op2[XLEN-1];
    divZeroIn = ID_EX_md_op[2] & (EX_md_op2 == '0);
    ovfIn     = ((ID_EX_md_op == MD_OP_DIV) | (ID_EX_md_op == MD_OP_REM)) &
                (EX_md_op1 == MIN_VAL) & (EX_md_op2 == {XLEN{1'b1}});
`ifdef EX_MD_EARLY_OUT_EN
    earlyIn   = divZeroIn | ovfIn |
                (~ID_EX_md_op[2] & ((EX_md_op1 == '0) | (EX_md_op2 == '0)));
`else
    earlyIn   = 1'b0;
`endif
  end

  ex_md_sign_fix #(.W(XLEN)) uMagA (.val_i(EX_md_op1), .neg_i(negA), .res_o(aMag));
  ex_md_sign_fix #(.W(XLEN)) uMagB (.val_i(EX_md_op2), .neg_i(negB), .res_o(bMag));

  // One iteration step. Multiply: accQ = {partial sum, multiplier}, add
  // the multiplicand on the multiplier LSB then shift right. Divide:
  // accQ = {remainder, quotient/dividend}, shift left and keep the
  // trial subtraction only when it does not borrow.
  always_comb begin
    mulSum   = {1'b0, accQ[2*XLEN-1:XLEN]} + (accQ[0] ? {1'b0, bQ} : {(XLEN+1){1'b0}});
    mulNext  = {mulSum, accQ[XLEN-1:1]};
    divShift = {accQ[2*XLEN-1:XLEN], accQ[XLEN-1]};
    divDiff  = divShift - {1'b0, bQ};
    divNext  = divDiff[XLEN] ? {divShift[XLEN-1:0], accQ[XLEN-2:0], 1'b0}
                             : {divDiff[XLEN-1:0],  accQ[XLEN-2:0], 1'b1};
    accNext  = opQ[2] ? divNext : mulNext;
  end

  ex_md_sign_fix #(.W(2*XLEN)) uFixProd (.val_i(accNext), .neg_i(negResQ), .res_o(prodFixed));

  // Result selection from the final iteration, applied on the CALC->DONE edge.
  always_comb begin
    divRaw = opQ[1] ? accNext[2*XLEN-1:XLEN] : accNext[XLEN-1:0];
    divNeg = opQ[1] ? negRemQ : negResQ;
  end

  ex_md_sign_fix #(.W(XLEN)) uFixDiv (.val_i(divRaw), .neg_i(divNeg), .res_o(divFixed));

  always_comb begin
    if (divZeroQ | ovfQ)      calcResult = specialResult(opQ, divZeroQ, dividendQ);
    else if (opQ[2])          calcResult = divFixed;
    else if (opQ == MD_OP_MUL) calcResult = prodFixed[XLEN-1:0];
    else                      calcResult = prodFixed[2*XLEN-1:XLEN];
    // Entering DONE straight from IDLE only happens on an early exit.
    doneResult = (stateQ == IDLE) ? specialResult(ID_EX_md_op, divZeroIn, EX_md_op1) : calcResult;
    doneRd     = (stateQ == IDLE) ? ID_EX_rd : rdQ;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Flush wins in every state; DONE always lasts a single cycle.
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (accept) stateD = earlyIn ? DONE : CALC;
      CALC:    if (EX_flush) stateD = IDLE;
               else if (cntQ == CW'(XLEN-1)) stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // Stall is forced low while reset is held so the pipeline sees a quiet unit.
  always_comb begin
    EX_md_busy = rst_n & (accept | (stateQ == CALC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opQ       <= '0;
      rdQ       <= '0;
      accQ      <= '0;
      bQ        <= '0;
      cntQ      <= '0;
      negResQ   <= 1'b0;
      negRemQ   <= 1'b0;
      divZeroQ  <= 1'b0;
      ovfQ      <= 1'b0;
      dividendQ <= '0;
    end else if (accept) begin
      opQ       <= ID_EX_md_op;
      rdQ       <= ID_EX_rd;
      accQ      <= {{XLEN{1'b0}}, aMag};
      bQ        <= bMag;
      cntQ      <= '0;
      negResQ   <= negA ^ negB;
      negRemQ   <= negA;
      divZeroQ  <= divZeroIn;
      ovfQ      <= ovfIn;
      dividendQ <= EX_md_op1;
    end else if (stateQ == CALC) begin
      accQ      <= accNext;
      cntQ      <= cntQ + CW'(1);
    end
  end

  // Output registers update only on entry to DONE, so a flush leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doneQ   <= 1'b0;
      resultQ <= '0;
      rdOutQ  <= '0;
    end else begin
      doneQ <= (stateD == DONE);
      if (stateD == DONE) begin
        resultQ <= doneResult;
        rdOutQ  <= doneRd;
      end
    end
  end

  assign EX_md_done   = doneQ;
  assign EX_md_result = resultQ;
  assign EX_md_rd     = rdOutQ;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit
// Scoreboard bench for ex_muldiv_unit at XLEN=32: stimulus pushes the
// hand-computed result/rd, a monitor pops and compares on every done pulse.
// Honours EX_MD_EARLY_OUT_EN for the expected latency of special cases.
module tb_ex_muldiv_unit;
  import ex_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] op1, op2;
  logic [4:0]  rd;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rdOut;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb[$];
  logic [31:0] lastResult;

  ex_muldiv_unit #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .ID_EX_md_valid(valid), .ID_EX_md_op(op),
    .EX_md_op1(op1), .EX_md_op2(op2), .ID_EX_rd(rd), .EX_flush(flush),
    .EX_md_busy(busy), .EX_md_done(done), .EX_md_result(result), .EX_md_rd(rdOut)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [36:0] exp;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0 result=0x%0h", result);
      end else begin
        exp = sb.pop_front();
        checkOutput("result", 64'(result), 64'(exp[36:5]));
        checkOutput("rd", 64'(rdOut), 64'(exp[4:0]));
      end
    end
  end

  // Issue one operation at the next negedge (cycle 0) and hold it until done.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] r, input logic [31:0] expRes, input bit special);
    int lat;
    int busyCnt;
    int doneCyc;
    lat = 33;
`ifdef EX_MD_EARLY_OUT_EN
    if (special) lat = 1;
`else
    if (special) lat = 33;
`endif
    sb.push_back({expRes, r});
    @(negedge clk);
    valid = 1'b1; op = o; op1 = a; op2 = b; rd = r;
    #1;
    busyCnt = busy ? 1 : 0;
    doneCyc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) begin
        doneCyc = c;
        break;
      end
    end
    valid = 1'b0;
    checkOutput("done_cycle", 64'(doneCyc), 64'(lat));
    checkOutput("busy_cycles", 64'(busyCnt), 64'(lat));
    if (doneCyc < 0 && sb.size() > 0) void'(sb.pop_back());
    lastResult = expRes;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; op = MD_OP_MUL; op1 = '0; op2 = '0; rd = '0; flush = 1'b0;
    lastResult = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_result", 64'(result), 64'd0);
    checkOutput("reset_rd", 64'(rdOut), 64'd0);
    rst_n = 1'b1;

    applyStimulus(MD_OP_MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 1'b0);
    applyStimulus(MD_OP_MULH,   32'h80000000,   32'h80000000, 5'd6,  32'h40000000, 1'b0);
    applyStimulus(MD_OP_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, 1'b0);
    applyStimulus(MD_OP_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, 1'b0);
    applyStimulus(MD_OP_DIV,    32'hFFFFFFF9,   32'd2,        5'd9,  32'hFFFFFFFD, 1'b0);
    applyStimulus(MD_OP_REM,    32'hFFFFFFF9,   32'd2,        5'd10, 32'hFFFFFFFF, 1'b0);
    applyStimulus(MD_OP_DIVU,   32'hFFFFFFF9,   32'd2,        5'd11, 32'h7FFFFFFC, 1'b0);
    applyStimulus(MD_OP_REMU,   32'd100,        32'd7,        5'd12, 32'd2,        1'b0);
    applyStimulus(MD_OP_DIV,    32'd5,          32'd0,        5'd13, 32'hFFFFFFFF, 1'b1);
    applyStimulus(MD_OP_REM,    32'd5,          32'd0,        5'd14, 32'd5,        1'b1);
    applyStimulus(MD_OP_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd15, 32'h80000000, 1'b1);
    applyStimulus(MD_OP_REM,    32'h80000000,   32'hFFFFFFFF, 5'd16, 32'd0,        1'b1);
    applyStimulus(MD_OP_MUL,    32'd0,          32'd123,      5'd17, 32'd0,        1'b1);
    applyStimulus(MD_OP_MULHU,  32'h00012345,   32'h00010000, 5'd18, 32'd1,        1'b0);

    // Flush at cycle 10 of an operation that would otherwise complete.
    @(negedge clk);
    valid = 1'b1; op = MD_OP_MUL; op1 = 32'h1234; op2 = 32'h10; rd = 5'd20;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    #1;
    checkOutput("flush_busy_c11", 64'(busy), 64'd0);
    checkOutput("flush_done_c11", 64'(done), 64'd0);
    checkOutput("flush_result_kept", 64'(result), 64'(lastResult));
    applyStimulus(MD_OP_DIVU, 32'd100, 32'd7, 5'd21, 32'd14, 1'b0);

    // Flush together with valid in IDLE is not accepted.
    @(negedge clk);
    valid = 1'b1; flush = 1'b1; op = MD_OP_DIV; op1 = 32'd9; op2 = 32'd3; rd = 5'd22;
    #1;
    checkOutput("flush_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;
    #1;
    checkOutput("flush_idle_busy_next", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("flush_idle_no_done", 64'(done), 64'd0);

    // Reset at cycle 20 of an operation discards it.
    @(negedge clk);
    valid = 1'b1; op = MD_OP_MUL; op1 = 32'd9; op2 = 32'd9; rd = 5'd23;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_done", 64'(done), 64'd0);
    checkOutput("midreset_result", 64'(result), 64'd0);
    checkOutput("midreset_rd", 64'(rdOut), 64'd0);
    sb.delete();
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    applyStimulus(MD_OP_MUL, 32'd3, 32'd4, 5'd24, 32'd12, 1'b0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
